// File: rtl/fft64_frame_sched.sv
// Frame scheduler / arbiter in front of a shared 64-point streaming FFT core.
// Grants whole 64-sample frames round-robin across NCH channels, feeds the core
// contiguously, captures and tags the 64 core outputs, then clears the core.
// Optional feature macro: FFT_SCHED_TIMEOUT_EN adds a WAIT_OUT watchdog (TIMEOUT cycles).
module fft64_frame_sched #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CLR_CYC = 2,
  parameter int unsigned TIMEOUT = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      req_valid,
  output logic [NCH-1:0]      req_ready,
  input  logic [12*NCH-1:0]   req_r,
  input  logic [12*NCH-1:0]   req_i,
  output logic                core_rst_n,
  output logic                core_in_vld,
  output logic [11:0]         core_din_r,
  output logic [11:0]         core_din_i,
  input  logic                core_out_vld,
  input  logic [15:0]         core_dout_r,
  input  logic [15:0]         core_dout_i,
  output logic                out_valid,
  output logic [15:0]         out_r,
  output logic [15:0]         out_i,
  output logic [2:0]          out_ch,
  output logic [5:0]          out_idx,
  output logic                out_last,
  output logic                err,
  output logic                busy
);

  localparam int unsigned SW   = 12;
  localparam int unsigned CW   = 3;
  localparam int unsigned IW   = 6;
  localparam int unsigned WDW  = 10;
  localparam int unsigned CLRW = (CLR_CYC < 2) ? 1 : $clog2(CLR_CYC);

  // Elaboration-time parameter sanity checks
  if (NCH < 2 || NCH > 8) begin : g_nch_chk
    $error("fft64_frame_sched: NCH must be in 2..8");
  end
  if (CLR_CYC < 1) begin : g_clr_chk
    $error("fft64_frame_sched: CLR_CYC must be at least 1");
  end
  if (TIMEOUT < 1 || TIMEOUT > 1024) begin : g_to_chk
    $error("fft64_frame_sched: TIMEOUT must be in 1..1024");
  end

  typedef enum logic [2:0] {
    S_CLEAR    = 3'd0,
    S_IDLE     = 3'd1,
    S_LOAD     = 3'd2,
    S_WAIT_OUT = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t          state;
  logic [CLRW-1:0] clr_cnt;
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   ch;
  logic [IW-1:0]   in_cnt;
  logic [IW-1:0]   out_cnt;
  logic            started;
  logic            vld_q;
`ifdef FFT_SCHED_TIMEOUT_EN
  logic [WDW-1:0]  wd_cnt;
`endif

  logic [CW-1:0]   gnt_ch;
  logic [NCH-1:0]  gnt_oh;
  int              off_c;
  int              best_c;
  logic [SW-1:0]   sel_r;
  logic [SW-1:0]   sel_i;
  logic            ch_valid;

  // Round-robin pick: lowest rotated distance from rr_ptr among requesters
  always_comb begin
    best_c = int'(NCH);
    off_c  = 0;
    gnt_ch = '0;
    for (int j = 0; j < int'(NCH); j++) begin
      off_c = (j >= int'(rr_ptr)) ? (j - int'(rr_ptr)) : (j + int'(NCH) - int'(rr_ptr));
      if (req_valid[j] && (off_c < best_c)) begin
        best_c = off_c;
        gnt_ch = CW'(j);
      end
    end
  end

  assign gnt_oh = NCH'(1) << gnt_ch;

  // Sample mux driven by the one-hot ready of the granted channel
  always_comb begin
    sel_r = '0;
    sel_i = '0;
    for (int j = 0; j < int'(NCH); j++) begin
      if (req_ready[j]) begin
        sel_r = req_r[j*SW +: SW];
        sel_i = req_i[j*SW +: SW];
      end
    end
  end

  assign ch_valid = |(req_valid & req_ready);

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_CLEAR;
      clr_cnt     <= '0;
      rr_ptr      <= '0;
      ch          <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      started     <= 1'b0;
      vld_q       <= 1'b0;
`ifdef FFT_SCHED_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
      req_ready   <= '0;
      core_rst_n  <= 1'b0;
      core_in_vld <= 1'b0;
      core_din_r  <= '0;
      core_din_i  <= '0;
      out_valid   <= 1'b0;
      out_r       <= '0;
      out_i       <= '0;
      out_ch      <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vld_q       <= core_out_vld;
      err         <= 1'b0;
      core_in_vld <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      case (state)
        S_CLEAR: begin
          if (clr_cnt == CLRW'(CLR_CYC - 1)) begin
            clr_cnt    <= '0;
            core_rst_n <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            clr_cnt <= clr_cnt + CLRW'(1);
          end
        end
        S_IDLE: begin
          if (|req_valid) begin
            ch        <= gnt_ch;
            req_ready <= gnt_oh;
            rr_ptr    <= (gnt_ch == CW'(NCH - 1)) ? '0 : gnt_ch + CW'(1);
            in_cnt    <= '0;
            started   <= 1'b0;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (ch_valid) begin
            core_in_vld <= 1'b1;
            core_din_r  <= sel_r;
            core_din_i  <= sel_i;
            started     <= 1'b1;
            in_cnt      <= in_cnt + IW'(1);
            if (in_cnt == IW'(63)) begin
              req_ready <= '0;
`ifdef FFT_SCHED_TIMEOUT_EN
              wd_cnt    <= '0;
`endif
              state     <= S_WAIT_OUT;
            end
          end else if (started) begin
            // Gap after the first accept breaks core contiguity: abort the frame
            err        <= 1'b1;
            req_ready  <= '0;
            core_rst_n <= 1'b0;
            clr_cnt    <= '0;
            state      <= S_CLEAR;
          end
        end
        S_WAIT_OUT: begin
          if (core_out_vld && !vld_q) begin
            out_valid <= 1'b1;
            out_r     <= core_dout_r;
            out_i     <= core_dout_i;
            out_ch    <= ch;
            out_idx   <= '0;
            out_cnt   <= IW'(1);
            state     <= S_DRAIN;
          end
`ifdef FFT_SCHED_TIMEOUT_EN
          else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
            err        <= 1'b1;
            core_rst_n <= 1'b0;
            clr_cnt    <= '0;
            state      <= S_CLEAR;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
`endif
        end
        S_DRAIN: begin
          out_valid <= 1'b1;
          out_r     <= core_dout_r;
          out_i     <= core_dout_i;
          out_idx   <= out_cnt;
          out_cnt   <= out_cnt + IW'(1);
          if (out_cnt == IW'(63)) begin
            out_last   <= 1'b1;
            core_rst_n <= 1'b0;
            clr_cnt    <= '0;
            state      <= S_CLEAR;
          end
        end
        default: begin
          core_rst_n <= 1'b0;
          clr_cnt    <= '0;
          state      <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft64_frame_sched.sv
// Directed bench for fft64_frame_sched with a small behavioural FFT-core stand-in.
module tb_fft64_frame_sched;

  localparam int NCH = 4;
  localparam int LAT = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [12*NCH-1:0] req_r;
  logic [12*NCH-1:0] req_i;
  logic              core_rst_n;
  logic              core_in_vld;
  logic [11:0]       core_din_r;
  logic [11:0]       core_din_i;
  logic              core_out_vld;
  logic [15:0]       core_dout_r;
  logic [15:0]       core_dout_i;
  logic              out_valid;
  logic [15:0]       out_r;
  logic [15:0]       out_i;
  logic [2:0]        out_ch;
  logic [5:0]        out_idx;
  logic              out_last;
  logic              err;
  logic              busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft64_frame_sched #(.NCH(NCH), .CLR_CYC(2), .TIMEOUT(512)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_r        (req_r),
    .req_i        (req_i),
    .core_rst_n   (core_rst_n),
    .core_in_vld  (core_in_vld),
    .core_din_r   (core_din_r),
    .core_din_i   (core_din_i),
    .core_out_vld (core_out_vld),
    .core_dout_r  (core_dout_r),
    .core_dout_i  (core_dout_i),
    .out_valid    (out_valid),
    .out_r        (out_r),
    .out_i        (out_i),
    .out_ch       (out_ch),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .err          (err),
    .busy         (busy)
  );

  // Core stand-in: after 64 inputs and LAT cycles, raises a sticky valid and
  // outputs (sum of real inputs, beat number + sum of imag inputs).
  logic [6:0]  m_in   = '0;
  logic [15:0] m_sr   = '0;
  logic [15:0] m_si   = '0;
  logic [7:0]  m_lat  = '0;
  logic        m_vld  = 1'b0;
  logic [15:0] m_k    = '0;
  logic        m_hang = 1'b0;

  always @(posedge clk) begin
    if (!core_rst_n) begin
      m_in <= '0; m_sr <= '0; m_si <= '0; m_lat <= '0; m_vld <= 1'b0; m_k <= '0;
    end else begin
      if (core_in_vld) begin
        m_in <= m_in + 7'd1;
        m_sr <= m_sr + {{4{core_din_r[11]}}, core_din_r};
        m_si <= m_si + {{4{core_din_i[11]}}, core_din_i};
      end
      if (m_in == 7'd64 && !m_vld && !m_hang) begin
        if (m_lat == 8'(LAT)) m_vld <= 1'b1;
        else m_lat <= m_lat + 8'd1;
      end
      if (m_vld) m_k <= m_k + 16'd1;
    end
  end

  assign core_out_vld = m_vld;
  assign core_dout_r  = m_sr;
  assign core_dout_i  = m_k + m_si;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one frame on channel c; sample 0 carries (ar, ai), the rest are zero.
  // gap_at >= 0 drops valid once that many samples have been accepted.
  task automatic drive_frame(input int c, input logic [11:0] ar, input logic [11:0] ai,
                             input int gap_at, output int accepted);
    int n = 0;
    int guard = 0;
    bit seen = 1'b0;
    bit gapped = 1'b0;
    while (n < 64 && guard < 400 && !gapped) begin
      @(negedge clk);
      guard++;
      if (!seen && req_ready != '0) begin
        seen = 1'b1;
        check("grant", 32'(req_ready), 32'(1) << c);
      end
      if (n == gap_at && req_ready[c]) begin
        req_valid[c] = 1'b0;
        gapped = 1'b1;
      end else begin
        req_valid[c] = 1'b1;
        req_r[c*12 +: 12] = (n == 0) ? ar : 12'd0;
        req_i[c*12 +: 12] = (n == 0) ? ai : 12'd0;
        if (req_ready[c]) n++;
      end
    end
    if (!gapped) begin
      @(negedge clk);
      req_valid[c] = 1'b0;
      req_r[c*12 +: 12] = '0;
      req_i[c*12 +: 12] = '0;
    end
    accepted = n;
  endtask

  // Check one full drain of 64 tagged beats, the following clear, and silence after.
  task automatic check_frame(input int exp_ch, input logic [15:0] exp_r, input logic [15:0] i_off);
    int guard = 0;
    int extra = 0;
    while (!out_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_start", 32'(out_valid), 32'd1);
    for (int k = 0; k < 64; k++) begin
      if (k != 0) @(negedge clk);
      check("beat_valid", 32'(out_valid), 32'd1);
      check("beat_idx", 32'(out_idx), 32'(k));
      check("beat_ch", 32'(out_ch), 32'(exp_ch));
      check("beat_r", 32'(out_r), 32'(exp_r));
      check("beat_i", 32'(out_i), 32'(16'(k) + i_off));
      check("beat_last", 32'(out_last), (k == 63) ? 32'd1 : 32'd0);
    end
    check("clr_at_last", 32'(core_rst_n), 32'd0);
    @(negedge clk);
    check("clr_cyc2", 32'(core_rst_n), 32'd0);
    check("valid_drop", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("clr_release", 32'(core_rst_n), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("no_extra_beats", 32'(extra), 32'd0);
  endtask

  int acc;
  int grants;
  int gch;
  int unstable;
  int gap_vld;
  logic [NCH-1:0] prev_rdy;
  int exp_rr [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_r = '0;
    req_i = '0;

    // Reset values
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_clear", 32'(core_rst_n), 32'd0);
    @(negedge clk);
    check("post_rst_idle", 32'(core_rst_n), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Single channel impulse on ch2
    drive_frame(2, 12'd256, 12'd0, -1, acc);
    check("t1_accepted", 32'(acc), 32'd64);
    check("t1_busy", 32'(busy), 32'd1);
    check_frame(2, 16'd256, 16'd0);

    // Gap on ch1 at sample 20 while ch2 also requests; rr_ptr is 3 here
    @(negedge clk);
    req_valid = 4'b0110;
    drive_frame(1, 12'd77, 12'd0, 20, acc);
    check("t3_accepted", 32'(acc), 32'd20);
    gap_vld = 0;
    @(negedge clk);
    check("t3_err_pulse", 32'(err), 32'd1);
    check("t3_clear", 32'(core_rst_n), 32'd0);
    if (out_valid) gap_vld++;
    @(negedge clk);
    check("t3_err_one_cycle", 32'(err), 32'd0);
    if (out_valid) gap_vld++;
    check("t3_no_output", 32'(gap_vld), 32'd0);
    drive_frame(2, 12'd100, 12'd5, -1, acc);
    check("t3_next_accepted", 32'(acc), 32'd64);
    check_frame(2, 16'd100, 16'd5);

    // Reset in the middle of a drain on ch3
    drive_frame(3, 12'd50, 12'd0, -1, acc);
    begin
      int guard = 0;
      while (!(out_valid && out_idx == 6'd30) && guard < 300) begin
        @(negedge clk);
        guard++;
      end
    end
    check("t4_reached_idx30", 32'(out_idx), 32'd30);
    rst_n = 1'b0;
    #1;
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_core_rst_n", 32'(core_rst_n), 32'd0);
    check("t4_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with all channels requesting, starting from a fresh rr_ptr
    req_valid = 4'hF;
    req_r = '0;
    req_i = '0;
    grants = 0;
    unstable = 0;
    prev_rdy = '0;
    for (int cyc = 0; cyc < 3000 && grants < 5; cyc++) begin
      @(negedge clk);
      if (req_ready != '0 && prev_rdy == '0) begin
        gch = -1;
        for (int j = 0; j < NCH; j++) if (req_ready[j]) gch = j;
        check("rr_onehot", 32'($onehot(req_ready)), 32'd1);
        check("rr_order", 32'(gch), 32'(exp_rr[grants]));
        grants++;
      end else if (req_ready != '0 && req_ready != prev_rdy) begin
        unstable++;
      end
      prev_rdy = req_ready;
    end
    check("rr_grants", 32'(grants), 32'd5);
    check("rr_ready_stable", 32'(unstable), 32'd0);
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Core never answers: watchdog (if built in) or indefinite wait
    m_hang = 1'b1;
    drive_frame(0, 12'd10, 12'd0, -1, acc);
    check("t5_accepted", 32'(acc), 32'd64);
    repeat (511) @(negedge clk);
    check("t5_no_early_err", 32'(err), 32'd0);
    @(negedge clk);
`ifdef FFT_SCHED_TIMEOUT_EN
    check("t5_timeout_err", 32'(err), 32'd1);
    @(negedge clk);
    check("t5_err_one_cycle", 32'(err), 32'd0);
    check("t5_clear", 32'(core_rst_n), 32'd0);
`else
    check("t5_no_err", 32'(err), 32'd0);
    repeat (100) @(negedge clk);
    check("t5_still_busy", 32'(busy), 32'd1);
    check("t5_no_output", 32'(out_valid), 32'd0);
`endif
    rst_n = 1'b0;
    m_hang = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
